dma_reg_responder: RTL and testbench

// - Register-file responder for the DMA control-register bus: the target that services
//   wr_en/rd_en/addr/wdata transactions and returns rdata.
// - Holds the DMA configuration registers and runs a word-counting transfer engine.
// - The engine raises done/error status and an interrupt; this is the DUT behind the bench driver/monitor.

---
 rtl/dma_reg_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dma_reg_responder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_reg_responder.sv
// DMA control-register target: register file, read mux and a word-counting transfer engine.
// Define DMA_SOFT_RESET_EN to enable the CTRL[31] soft abort.
module dma_reg_responder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_intr
);

    localparam logic [11:0] OFF_INTR   = 12'h400;
    localparam logic [11:0] OFF_CTRL   = 12'h404;
    localparam logic [11:0] OFF_IO     = 12'h408;
    localparam logic [11:0] OFF_MEM    = 12'h40C;
    localparam logic [11:0] OFF_STATUS = 12'h410;
    localparam logic [11:0] OFF_XFER   = 12'h414;
    localparam logic [11:0] OFF_ERR    = 12'h418;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [15:0]       r_intr_mask;
    logic [1:0]        r_intr_stat;
    logic [14:0]       r_w_count;
    logic              r_io_mem;
    logic [DATA_W-1:0] r_io_addr;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_xfer_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic [15:0]       r_remaining;
    logic              r_done;
    logic              r_error;
    logic [4:0]        r_err_stat;

    logic [11:0]       w_off;
    logic [DATA_W-1:0] w_rd_val;
    logic              w_busy;
    logic              w_wr_intr;
    logic              w_wr_err;
    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_abort;
    logic [2:0]        w_chk;
    logic              w_accept;
    logic              w_chk_err;
    logic              w_busy_err;
    logic              w_step;
    logic              w_finish;
    logic [1:0]        w_intr_w1c;
    logic [4:0]        w_err_w1c;
    logic [4:0]        w_err_set;
    logic              w_unused_addr;

    // Only the low 12 address bits are decoded.
    assign w_off         = i_addr[11:0];
    assign w_unused_addr = ^i_addr;
    assign w_busy        = (r_state != StIdle);
    assign w_wr_intr     = i_wr_en && (w_off == OFF_INTR);
    assign w_wr_err      = i_wr_en && (w_off == OFF_ERR);
    assign w_ctrl_wr     = i_wr_en && (w_off == OFF_CTRL);
    assign w_start       = w_ctrl_wr & i_wdata[0];

`ifdef DMA_SOFT_RESET_EN
    assign w_abort = w_ctrl_wr & i_wdata[31];
`else
    assign w_abort = 1'b0;
`endif

    // Start checks: new word count, currently programmed addresses.
    assign w_chk = {|r_mem_addr[1:0], |r_io_addr[1:0], (i_wdata[15:1] == 15'd0)};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_chk_err   = 1'b0;
        w_busy_err  = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        if (w_abort) begin
            w_state_nxt = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        if (|w_chk) begin
                            w_chk_err = 1'b1;
                        end else begin
                            w_accept    = 1'b1;
                            w_state_nxt = StRun;
                        end
                    end
                end
                StRun: begin
                    w_step     = 1'b1;
                    w_busy_err = w_start;
                    if (r_remaining == 16'd1) begin
                        w_state_nxt = StDone;
                    end
                end
                StDone: begin
                    w_finish    = 1'b1;
                    w_busy_err  = w_start;
                    w_state_nxt = StIdle;
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    assign w_intr_w1c = w_wr_intr ? i_wdata[1:0] : 2'b00;
    assign w_err_w1c  = w_wr_err ? i_wdata[4:0] : 5'd0;
    assign w_err_set  = {w_abort, w_busy_err, w_chk & {3{w_chk_err}}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_intr_mask <= '0;
            r_intr_stat <= '0;
            r_w_count   <= '0;
            r_io_mem    <= 1'b0;
            r_io_addr   <= '0;
            r_mem_addr  <= '0;
            r_xfer_cnt  <= '0;
            r_rdata     <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_stat  <= '0;
        end else begin
            if (w_wr_intr) begin
                r_intr_mask <= i_wdata[31:16];
            end
            // Hardware set wins over a same-cycle write-1-to-clear.
            r_intr_stat <= (r_intr_stat & ~w_intr_w1c) | {w_chk_err | w_busy_err, w_finish};
            r_err_stat  <= (r_err_stat & ~w_err_w1c) | w_err_set;
            if (w_ctrl_wr && !w_busy) begin
                r_w_count <= i_wdata[15:1];
                r_io_mem  <= i_wdata[16];
            end
            if (i_wr_en && !w_busy && (w_off == OFF_IO)) begin
                r_io_addr <= i_wdata;
            end
            if (i_wr_en && !w_busy && (w_off == OFF_MEM)) begin
                r_mem_addr <= i_wdata;
            end
            if (w_abort) begin
                r_remaining <= '0;
            end else if (w_accept) begin
                r_remaining <= {1'b0, i_wdata[15:1]};
            end else if (w_step) begin
                r_remaining <= r_remaining - 16'd1;
            end
            if (w_step) begin
                r_xfer_cnt <= r_xfer_cnt + DATA_W'(1);
            end
            if (w_abort || w_accept) begin
                r_done <= 1'b0;
            end else if (w_finish) begin
                r_done <= 1'b1;
            end
            if (w_abort || w_chk_err) begin
                r_error <= 1'b1;
            end else if (w_accept) begin
                r_error <= 1'b0;
            end
            if (i_rd_en) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            OFF_INTR:   w_rd_val = {r_intr_mask, 14'd0, r_intr_stat};
            OFF_CTRL:   w_rd_val = {15'd0, r_io_mem, r_w_count, 1'b0};
            OFF_IO:     w_rd_val = r_io_addr;
            OFF_MEM:    w_rd_val = r_mem_addr;
            OFF_STATUS: w_rd_val = {r_remaining, 13'd0, r_error, r_done, w_busy};
            OFF_XFER:   w_rd_val = r_xfer_cnt;
            OFF_ERR:    w_rd_val = {27'd0, r_err_stat};
            default:    w_rd_val = '0;
        endcase
    end

    assign o_rdata = r_rdata;
    assign o_intr  = |(r_intr_stat & r_intr_mask[1:0]);

endmodule

// File: tb/tb_dma_reg_responder.sv
// Bench for dma_reg_responder: directed and randomized transfers against a register-level model.
// Define DMA_SOFT_RESET_EN to exercise the soft abort instead of the reserved-bit check.
module tb_dma_reg_responder;

    localparam logic [31:0] A_INTR   = 32'h0000_0400;
    localparam logic [31:0] A_CTRL   = 32'h0000_0404;
    localparam logic [31:0] A_IO     = 32'h0000_0408;
    localparam logic [31:0] A_MEM    = 32'h0000_040C;
    localparam logic [31:0] A_STATUS = 32'h0000_0410;
    localparam logic [31:0] A_XFER   = 32'h0000_0414;
    localparam logic [31:0] A_ERR    = 32'h0000_0418;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        intr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural register contents.
    logic [31:0] m_io = '0, m_mem = '0, m_xfer = '0;
    logic [15:0] m_mask = '0;
    logic [1:0]  m_stat = '0;
    logic [4:0]  m_err = '0;
    logic        m_done = 1'b0, m_error = 1'b0, m_iomem = 1'b0;
    logic [14:0] m_wc = '0;

    always #5 clk = ~clk;

    dma_reg_responder #(.DATA_W(32), .ADDR_W(32)) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_wr_en(wr_en),
        .i_rd_en(rd_en),
        .i_addr (addr),
        .i_wdata(wdata),
        .o_rdata(rdata),
        .o_intr (intr)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Bus tasks start and end at a falling edge; each takes one cycle.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic model_reset();
        m_io = '0; m_mem = '0; m_xfer = '0; m_mask = '0; m_stat = '0; m_err = '0;
        m_done = 1'b0; m_error = 1'b0; m_iomem = 1'b0; m_wc = '0;
    endtask

    task automatic model_start(input int w, input logic iom, output bit ok);
        logic [4:0] e;
        e = {2'b00, m_mem[1:0] != 2'b00, m_io[1:0] != 2'b00, w == 0};
        m_wc = 15'(w); m_iomem = iom;
        if (e != 5'd0) begin
            m_err = m_err | e; m_error = 1'b1; m_stat[1] = 1'b1; ok = 1'b0;
        end else begin
            m_done = 1'b0; m_error = 1'b0; ok = 1'b1;
        end
    endtask

    function automatic logic [31:0] status_word(logic busy, logic done, logic err, logic [15:0] rem);
        return {rem, 13'd0, err, done, busy};
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b want 0", intr); end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 7; i++) begin
            bus_read(A_INTR + 32'(4 * i), v);
            n_tests++;
            if (v !== 32'd0) begin
                n_fail++; $display("FAIL reset_reg_%0d: got %h want 0", i, v);
            end
        end
    endtask

    task automatic test_rw();
        logic [31:0] v, r1, r2;
        bus_write(A_IO, 32'h1000_0000); m_io = 32'h1000_0000;
        bus_write(A_MEM, 32'h2000_0000); m_mem = 32'h2000_0000;
        bus_read(A_IO, v);
        n_tests++;
        if (v !== m_io) begin n_fail++; $display("FAIL rw_io: got %h want %h", v, m_io); end
        bus_read(A_MEM, v);
        n_tests++;
        if (v !== m_mem) begin n_fail++; $display("FAIL rw_mem: got %h want %h", v, m_mem); end
        bus_read(32'h0000_0500, v);
        n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL rw_unmapped: got %h want 0", v); end
        for (int i = 0; i < 3; i++) begin
            r1 = $urandom; r2 = $urandom;
            bus_write(A_IO, r1); m_io = r1;
            bus_write(A_MEM, r2); m_mem = r2;
            bus_read(A_IO, v);
            n_tests++;
            if (v !== m_io) begin n_fail++; $display("FAIL rw_rand_io: got %h want %h", v, m_io); end
            bus_read(A_MEM, v);
            n_tests++;
            if (v !== m_mem) begin n_fail++; $display("FAIL rw_rand_mem: got %h want %h", v, m_mem); end
        end
        bus_write(A_IO, 32'h1000_0000); m_io = 32'h1000_0000;
        bus_write(A_MEM, 32'h2000_0000); m_mem = 32'h2000_0000;
        bus_write(32'h0000_0409, 32'hDEAD_BEEF);
        bus_read(A_IO, v);
        n_tests++;
        if (v !== m_io) begin n_fail++; $display("FAIL rw_misaligned_wr: got %h want %h", v, m_io); end
        bus_read(32'hABCD_0408, v);
        n_tests++;
        if (v !== m_io) begin n_fail++; $display("FAIL rw_upper_addr: got %h want %h", v, m_io); end
        bus_read(32'h0000_040A, v);
        n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL rw_misaligned_rd: got %h want 0", v); end
    endtask

    task automatic test_transfer();
        logic [31:0] v, exp;
        bit ok;
        int w;
        w = 4;
        bus_write(A_INTR, 32'h0001_0000); m_mask = 16'h0001;
        bus_write(A_CTRL, 32'h0000_0009);
        model_start(w, 1'b0, ok);
        for (int k = 0; k <= w + 1; k++) begin
            bus_read(A_STATUS, v);
            exp = (k <= w) ? status_word(1'b1, 1'b0, 1'b0, 16'(w - k))
                           : status_word(1'b0, 1'b1, 1'b0, 16'd0);
            n_tests++;
            if (v !== exp) begin n_fail++; $display("FAIL xfer_status_k%0d: got %h want %h", k, v, exp); end
        end
        m_done = 1'b1; m_stat[0] = 1'b1; m_xfer = m_xfer + 32'(w);
        bus_read(A_XFER, v);
        n_tests++;
        if (v !== m_xfer) begin n_fail++; $display("FAIL xfer_cnt: got %h want %h", v, m_xfer); end
        n_tests++;
        if (intr !== 1'b1) begin n_fail++; $display("FAIL xfer_intr: got %b want 1", intr); end
        bus_write(A_INTR, 32'h0000_0001); m_mask = 16'h0; m_stat[0] = 1'b0;
        n_tests++;
        if (intr !== 1'b0) begin n_fail++; $display("FAIL xfer_intr_clr: got %b want 0", intr); end
        bus_read(A_INTR, v);
        n_tests++;
        if (v !== {m_mask, 14'd0, m_stat}) begin
            n_fail++; $display("FAIL xfer_intr_reg: got %h want %h", v, {m_mask, 14'd0, m_stat});
        end
    endtask

    task automatic test_errors();
        logic [31:0] v;
        bit ok;
        bus_write(A_ERR, 32'h0000_001F); m_err = '0;
        bus_write(A_CTRL, 32'h0000_0001);
        model_start(0, 1'b0, ok);
        bus_read(A_ERR, v);
        n_tests++;
        if (v !== {27'd0, m_err}) begin n_fail++; $display("FAIL err_zero: got %h want %h", v, {27'd0, m_err}); end
        bus_read(A_STATUS, v);
        n_tests++;
        if (v !== status_word(1'b0, m_done, m_error, 16'd0)) begin
            n_fail++; $display("FAIL err_zero_status: got %h want %h", v, status_word(1'b0, m_done, m_error, 16'd0));
        end
        bus_read(A_INTR, v);
        n_tests++;
        if (v !== {m_mask, 14'd0, m_stat}) begin
            n_fail++; $display("FAIL err_intr_stat: got %h want %h", v, {m_mask, 14'd0, m_stat});
        end
        bus_write(A_ERR, 32'h0000_0001); m_err[0] = 1'b0;
        bus_write(A_IO, 32'h0000_1002); m_io = 32'h0000_1002;
        bus_write(A_CTRL, 32'h0000_0005);
        model_start(2, 1'b0, ok);
        repeat (3) @(negedge clk);
        bus_read(A_ERR, v);
        n_tests++;
        if (v !== {27'd0, m_err}) begin n_fail++; $display("FAIL err_io_align: got %h want %h", v, {27'd0, m_err}); end
        bus_read(A_STATUS, v);
        n_tests++;
        if (v !== status_word(1'b0, m_done, m_error, 16'd0)) begin
            n_fail++; $display("FAIL err_no_run: got %h want %h", v, status_word(1'b0, m_done, m_error, 16'd0));
        end
        bus_read(A_XFER, v);
        n_tests++;
        if (v !== m_xfer) begin n_fail++; $display("FAIL err_xfer: got %h want %h", v, m_xfer); end
        bus_write(A_IO, 32'h1000_0000); m_io = 32'h1000_0000;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, nv;
        bit ok;
        bus_write(A_ERR, 32'h0000_001F); m_err = '0;
        bus_write(A_INTR, 32'h0003_0003); m_mask = 16'h0003; m_stat = 2'b00;
        bus_write(A_CTRL, 32'h0000_0011);
        model_start(8, 1'b0, ok);
        @(negedge clk);
        bus_write(A_CTRL, 32'h0001_0007);   // second START while running
        m_err[3] = 1'b1; m_stat[1] = 1'b1;
        bus_write(A_IO, 32'h7777_0000);     // must be ignored while busy
        repeat (8) @(negedge clk);
        m_done = 1'b1; m_stat[0] = 1'b1; m_xfer = m_xfer + 32'd8;
        bus_read(A_ERR, v);
        n_tests++;
        if (v !== {27'd0, m_err}) begin n_fail++; $display("FAIL b2b_err: got %h want %h", v, {27'd0, m_err}); end
        bus_read(A_XFER, v);
        n_tests++;
        if (v !== m_xfer) begin n_fail++; $display("FAIL b2b_xfer: got %h want %h", v, m_xfer); end
        bus_read(A_STATUS, v);
        n_tests++;
        if (v !== status_word(1'b0, m_done, m_error, 16'd0)) begin
            n_fail++; $display("FAIL b2b_status: got %h want %h", v, status_word(1'b0, m_done, m_error, 16'd0));
        end
        bus_read(A_CTRL, v);
        n_tests++;
        if (v !== {15'd0, m_iomem, m_wc, 1'b0}) begin
            n_fail++; $display("FAIL b2b_ctrl: got %h want %h", v, {15'd0, m_iomem, m_wc, 1'b0});
        end
        bus_read(A_IO, v);
        n_tests++;
        if (v !== m_io) begin n_fail++; $display("FAIL b2b_io: got %h want %h", v, m_io); end
        n_tests++;
        if (intr !== 1'b1) begin n_fail++; $display("FAIL b2b_intr: got %b want 1", intr); end
        nv = $urandom & 32'hFFFF_FFFC;
        wr_en = 1'b1; rd_en = 1'b1; addr = A_MEM; wdata = nv;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; v = rdata;
        n_tests++;
        if (v !== m_mem) begin n_fail++; $display("FAIL wr_rd_same: got %h want %h", v, m_mem); end
        m_mem = nv;
        bus_read(A_MEM, v);
        n_tests++;
        if (v !== m_mem) begin n_fail++; $display("FAIL wr_rd_after: got %h want %h", v, m_mem); end
    endtask

    task automatic test_random();
        logic [31:0] v, exp, io, mem;
        logic [15:0] mask;
        logic        iom;
        bit          ok;
        int          w;
        for (int it = 0; it < 6; it++) begin
            mask = 16'($urandom);
            bus_write(A_INTR, {mask, 16'hFFFF}); m_mask = mask; m_stat = 2'b00;
            bus_write(A_ERR, 32'h0000_001F); m_err = '0;
            io = $urandom; mem = $urandom;
            if ($urandom_range(0, 3) != 0) io[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) mem[1:0] = 2'b00;
            bus_write(A_IO, io); m_io = io;
            bus_write(A_MEM, mem); m_mem = mem;
            w = $urandom_range(0, 12);
            iom = 1'($urandom_range(0, 1));
            bus_write(A_CTRL, {15'd0, iom, 15'(w), 1'b1});
            model_start(w, iom, ok);
            if (ok) begin
                for (int k = 0; k <= w + 1; k++) begin
                    bus_read(A_STATUS, v);
                    exp = (k <= w) ? status_word(1'b1, 1'b0, 1'b0, 16'(w - k))
                                   : status_word(1'b0, 1'b1, 1'b0, 16'd0);
                    n_tests++;
                    if (v !== exp) begin
                        n_fail++; $display("FAIL rand%0d_status_k%0d: got %h want %h", it, k, v, exp);
                    end
                end
                m_done = 1'b1; m_stat[0] = 1'b1; m_xfer = m_xfer + 32'(w);
            end else begin
                bus_read(A_STATUS, v);
                n_tests++;
                if (v !== status_word(1'b0, m_done, m_error, 16'd0)) begin
                    n_fail++;
                    $display("FAIL rand%0d_status_err: got %h want %h", it, v, status_word(1'b0, m_done, m_error, 16'd0));
                end
            end
            bus_read(A_ERR, v);
            n_tests++;
            if (v !== {27'd0, m_err}) begin n_fail++; $display("FAIL rand%0d_err: got %h want %h", it, v, {27'd0, m_err}); end
            bus_read(A_XFER, v);
            n_tests++;
            if (v !== m_xfer) begin n_fail++; $display("FAIL rand%0d_xfer: got %h want %h", it, v, m_xfer); end
            bus_read(A_INTR, v);
            n_tests++;
            if (v !== {m_mask, 14'd0, m_stat}) begin
                n_fail++; $display("FAIL rand%0d_intr_reg: got %h want %h", it, v, {m_mask, 14'd0, m_stat});
            end
            bus_read(A_CTRL, v);
            n_tests++;
            if (v !== {15'd0, m_iomem, m_wc, 1'b0}) begin
                n_fail++; $display("FAIL rand%0d_ctrl: got %h want %h", it, v, {15'd0, m_iomem, m_wc, 1'b0});
            end
            n_tests++;
            if (intr !== |(m_stat & m_mask[1:0])) begin
                n_fail++; $display("FAIL rand%0d_intr: got %b want %b", it, intr, |(m_stat & m_mask[1:0]));
            end
        end
        bus_write(A_IO, 32'h1000_0000); m_io = 32'h1000_0000;
        bus_write(A_MEM, 32'h2000_0000); m_mem = 32'h2000_0000;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] v;
        bus_write(A_INTR, 32'h0003_0000); m_mask = 16'h0003;
        bus_write(A_CTRL, 32'h0000_0015);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (rdata !== 32'd0) begin n_fail++; $display("FAIL rst_async_rdata: got %h want 0", rdata); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (12) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            bus_read(A_INTR + 32'(4 * i), v);
            n_tests++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL rst_mid_reg_%0d: got %h want 0", i, v); end
        end
        n_tests++;
        if (intr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_intr: got %b want 0", intr); end
    endtask

`ifdef DMA_SOFT_RESET_EN
    task automatic test_soft_abort();
        logic [31:0] v;
        bit ok;
        bus_write(A_INTR, 32'h0003_0000); m_mask = 16'h0003;
        bus_write(A_CTRL, 32'h0000_0015);
        model_start(10, 1'b0, ok);
        repeat (3) @(negedge clk);
        bus_write(A_CTRL, 32'h8000_0000);
        m_xfer = m_xfer + 32'd3; m_done = 1'b0; m_error = 1'b1; m_err[4] = 1'b1;
        repeat (12) @(negedge clk);
        bus_read(A_STATUS, v);
        n_tests++;
        if (v !== status_word(1'b0, m_done, m_error, 16'd0)) begin
            n_fail++; $display("FAIL abort_status: got %h want %h", v, status_word(1'b0, m_done, m_error, 16'd0));
        end
        bus_read(A_ERR, v);
        n_tests++;
        if (v !== {27'd0, m_err}) begin n_fail++; $display("FAIL abort_err: got %h want %h", v, {27'd0, m_err}); end
        bus_read(A_XFER, v);
        n_tests++;
        if (v !== m_xfer) begin n_fail++; $display("FAIL abort_xfer: got %h want %h", v, m_xfer); end
        bus_read(A_CTRL, v);
        n_tests++;
        if (v !== {15'd0, m_iomem, m_wc, 1'b0}) begin
            n_fail++; $display("FAIL abort_ctrl: got %h want %h", v, {15'd0, m_iomem, m_wc, 1'b0});
        end
        n_tests++;
        if (intr !== 1'b0) begin n_fail++; $display("FAIL abort_intr: got %b want 0", intr); end
    endtask
`else
    task automatic test_reserved_bit();
        logic [31:0] v;
        bus_write(A_CTRL, 32'h8000_0000); m_wc = '0; m_iomem = 1'b0;
        bus_read(A_CTRL, v);
        n_tests++;
        if (v !== {15'd0, m_iomem, m_wc, 1'b0}) begin
            n_fail++; $display("FAIL rsvd_ctrl: got %h want %h", v, {15'd0, m_iomem, m_wc, 1'b0});
        end
        bus_read(A_ERR, v);
        n_tests++;
        if (v !== {27'd0, m_err}) begin n_fail++; $display("FAIL rsvd_err: got %h want %h", v, {27'd0, m_err}); end
        bus_read(A_STATUS, v);
        n_tests++;
        if (v !== status_word(1'b0, m_done, m_error, 16'd0)) begin
            n_fail++; $display("FAIL rsvd_status: got %h want %h", v, status_word(1'b0, m_done, m_error, 16'd0));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rw();
        test_transfer();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
`ifdef DMA_SOFT_RESET_EN
        test_soft_abort();
`else
        test_reserved_bit();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
